spi_slave_tx_mlane: RTL and testbench

//  Parametrised SPI slave transmit engine with 1/2/4 data lanes, run on the system clock.

---
 rtl/spi_slave_tx_mlane_pkg.sv | 49 ++++
 rtl/spi_slave_tx_mlane_if.sv | 35 +++
 rtl/spi_slave_tx_mlane_fifo.sv | 64 ++++++
 rtl/spi_slave_tx_mlane.sv | 155 +++++++++++++++
 tb/tb_spi_slave_tx_mlane.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_tx_mlane_pkg.sv
// ----------------------------------------------------------------------------
// spi_slave_pkg : shared types and helpers for the multi-lane SPI slave TX engine
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spi_slave_pkg;

  typedef enum logic [1:0] {
    SPI_MODE_SINGLE = 2'd0,
    SPI_MODE_DUAL   = 2'd1,
    SPI_MODE_QUAD   = 2'd2
  } spi_lane_mode_e;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_e;

  localparam int SPI_DEFAULT_CNT_TRGT = 7;

  // The reserved encoding 2'b11 falls back to single-lane operation.
  function automatic spi_lane_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return SPI_MODE_DUAL;
      2'b10:   return SPI_MODE_QUAD;
      default: return SPI_MODE_SINGLE;
    endcase
  endfunction

  function automatic int unsigned lane_count(input spi_lane_mode_e m);
    case (m)
      SPI_MODE_DUAL: return 2;
      SPI_MODE_QUAD: return 4;
      default:       return 1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input spi_lane_mode_e m);
    case (m)
      SPI_MODE_DUAL: return 4'b0011;
      SPI_MODE_QUAD: return 4'b1111;
      default:       return 4'b0001;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_slave_tx_mlane_if.sv
// ----------------------------------------------------------------------------
// spi_slave_tx_mlane_if : pad, control and push-side signals of the SPI TX engine
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface spi_slave_tx_mlane_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic                  spi_sclk_i;
  logic                  spi_cs_i;
  logic [1:0]            mode_i;
  logic [CNT_WIDTH-1:0]  cnt_i;
  logic                  cnt_upd_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  data_valid_i;
  logic                  data_ready_o;
  logic [3:0]            spi_sdo_o;
  logic [3:0]            spi_oe_o;
  logic                  done_o;
  logic                  underrun_o;

  modport slave (
    input  spi_sclk_i, spi_cs_i, mode_i, cnt_i, cnt_upd_i, data_i, data_valid_i,
    output data_ready_o, spi_sdo_o, spi_oe_o, done_o, underrun_o
  );

  modport master (
    output spi_sclk_i, spi_cs_i, mode_i, cnt_i, cnt_upd_i, data_i, data_valid_i,
    input  data_ready_o, spi_sdo_o, spi_oe_o, done_o, underrun_o
  );
endinterface

`default_nettype wire

// File: rtl/spi_slave_tx_mlane_fifo.sv
// ----------------------------------------------------------------------------
// spi_slave_tx_fifo : TX word FIFO, valid/ready push, pop strobe, no bypass
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_slave_tx_fifo
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_valid_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  push_ready_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  empty_o,
  output logic                  full_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;

  assign full_o       = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o      = (count_q == '0);
  assign push_ready_o = ~full_o;
  assign push         = push_valid_i & ~full_o;
  assign pop          = pop_i & ~empty_o;
  assign pop_data_o   = mem_q[rd_ptr_q];

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data_i;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_slave_tx_mlane.sv
// ----------------------------------------------------------------------------
// spi_slave_tx_mlane : 1/2/4-lane SPI slave TX engine (CPOL0/CPHA0), system-clock based
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_slave_tx_mlane
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  spi_slave_tx_mlane_if.slave bus
);
  localparam int WCNT_W = $clog2(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic                   sclk_sync, cs_sync, fe, cs_rise;
  tx_state_e              state_q, state_d;
  spi_lane_mode_e         mode_q, mode_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, target_q, target_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d, wcnt_last;
  logic [DATA_WIDTH-1:0]  sr_q, sr_d;
  logic                   done_q, done_d, underrun_q, underrun_d;
  logic                   load_word, fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0]  fifo_rdata;
  logic [3:0]             sdo;

  spi_slave_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_valid_i (bus.data_valid_i),
    .push_data_i  (bus.data_i),
    .push_ready_o (bus.data_ready_o),
    .pop_i        (load_word),
    .pop_data_o   (fifo_rdata),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk_i};
  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_i};
  assign sclk_sync   = sclk_sync_q[SYNC_STAGES-1];
  assign cs_sync     = cs_sync_q[SYNC_STAGES-1];
  assign sclk_prev_d = sclk_sync;
  assign cs_prev_d   = cs_sync;
  assign fe          = sclk_prev_q & ~sclk_sync;
  assign cs_rise     = cs_sync & ~cs_prev_q;
  assign wcnt_last   = WCNT_W'(DATA_WIDTH / lane_count(mode_q) - 1);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    wcnt_d     = wcnt_q;
    sr_d       = sr_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    load_word  = 1'b0;
    // A start strobe outranks deselect and any edge detected in the same cycle.
    if (bus.cnt_upd_i) begin
      target_d  = bus.cnt_i;
      mode_d    = decode_mode(bus.mode_i);
      cnt_d     = '0;
      wcnt_d    = '0;
      state_d   = TX_SHIFT;
      load_word = 1'b1;
    end else if (cs_rise || (state_q == TX_SHIFT && cs_sync)) begin
      state_d  = TX_IDLE;
      cnt_d    = '0;
      target_d = CNT_WIDTH'(SPI_DEFAULT_CNT_TRGT);
      wcnt_d   = '0;
      sr_d     = '0;
    end else if (state_q == TX_SHIFT && fe) begin
      if (cnt_q == target_q) begin
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = TX_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (wcnt_q == wcnt_last) begin
          wcnt_d    = '0;
          load_word = 1'b1;
        end else begin
          sr_d   = sr_q << lane_count(mode_q);
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
    end
    if (load_word) begin
      if (fifo_empty) begin
        sr_d       = '0;
        underrun_d = 1'b1;
      end else begin
        sr_d = fifo_rdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= TX_IDLE;
      mode_q      <= SPI_MODE_SINGLE;
      cnt_q       <= '0;
      target_q    <= CNT_WIDTH'(SPI_DEFAULT_CNT_TRGT);
      wcnt_q      <= '0;
      sr_q        <= '0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      wcnt_q      <= wcnt_d;
      sr_q        <= sr_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    sdo = '0;
    case (mode_q)
      SPI_MODE_DUAL: sdo[1:0] = sr_q[DATA_WIDTH-1 -: 2];
      SPI_MODE_QUAD: sdo      = sr_q[DATA_WIDTH-1 -: 4];
      default:       sdo[0]   = sr_q[DATA_WIDTH-1];
    endcase
  end

  assign bus.spi_sdo_o  = sdo;
  assign bus.spi_oe_o   = (state_q == TX_SHIFT && !cs_sync) ? lane_mask(mode_q) : 4'b0000;
  assign bus.done_o     = done_q;
  assign bus.underrun_o = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_tx_mlane.sv
// ----------------------------------------------------------------------------
// tb_spi_slave_tx_mlane : randomized bench with a bit-stream reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_slave_tx_mlane;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int SYNC  = 2;
  localparam int HALF  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_tx_mlane_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus_if ();

  spi_slave_tx_mlane #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if.slave)
  );

  int tests = 0;
  int fails = 0;
  int fall_idx = 0;
  int done_log[$];
  int ur_log[$];
  logic [DW-1:0] mq[$];

  // Pulse outputs are logged with the SCLK fall count at which they appeared.
  always @(negedge clk) begin
    if (bus_if.done_o === 1'b1) done_log.push_back(fall_idx);
    if (bus_if.underrun_o === 1'b1) ur_log.push_back(fall_idx);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    logic exp_rdy;
    exp_rdy = (mq.size() < DEPTH);
    bus_if.data_i = w;
    bus_if.data_valid_i = 1'b1;
    tests++;
    if (bus_if.data_ready_o !== exp_rdy) begin
      fails++;
      $display("FAIL push_ready: got %b expected %b", bus_if.data_ready_o, exp_rdy);
    end
    tick(1);
    bus_if.data_valid_i = 1'b0;
    if (exp_rdy) mq.push_back(w);
  endtask

  task automatic run_xfer(input int mode, input int cnt, input int abort_after, input bit coinc,
                          input bit push_upd, input logic [DW-1:0] push_w, input string name);
    int L, E, last, d0, u0;
    int exp_ur[$];
    logic [DW-1:0] cur;
    logic [3:0] mask, exp_sdo;
    bit acc;
    L    = (mode == 1) ? 2 : (mode == 2) ? 4 : 1;
    E    = DW / L;
    mask = 4'((1 << L) - 1);
    last = (abort_after >= 0) ? abort_after : cnt;
    d0 = done_log.size();
    u0 = ur_log.size();
    fall_idx = 0;
    cur = '0;
    bus_if.spi_cs_i = 1'b0;
    tick(SYNC + 2);
    if (coinc) begin
      bus_if.spi_sclk_i = 1'b1;
      tick(HALF);
      bus_if.spi_sclk_i = 1'b0;
      tick(2);
    end
    bus_if.mode_i    = 2'(mode);
    bus_if.cnt_i     = CW'(cnt);
    bus_if.cnt_upd_i = 1'b1;
    acc = push_upd && (mq.size() < DEPTH);
    if (push_upd) begin
      bus_if.data_i = push_w;
      bus_if.data_valid_i = 1'b1;
      tests++;
      if (bus_if.data_ready_o !== acc) begin
        fails++;
        $display("FAIL %s upd_ready: got %b expected %b", name, bus_if.data_ready_o, acc);
      end
    end
    tick(1);
    bus_if.cnt_upd_i    = 1'b0;
    bus_if.data_valid_i = 1'b0;
    bus_if.mode_i       = 2'($urandom);
    bus_if.cnt_i        = CW'($urandom);
    tick(2);
    for (int k = 0; k <= last; k++) begin
      if (k % E == 0) begin
        if (mq.size() > 0) cur = mq.pop_front();
        else begin
          cur = '0;
          exp_ur.push_back(k);
        end
        if (k == 0 && acc) mq.push_back(push_w);
      end
      exp_sdo = 4'((cur >> (DW - L * ((k % E) + 1))) & DW'(mask));
      tests++;
      if (bus_if.spi_sdo_o !== exp_sdo) begin
        fails++;
        $display("FAIL %s sdo bit %0d: got %h expected %h", name, k, bus_if.spi_sdo_o, exp_sdo);
      end
      tests++;
      if (bus_if.spi_oe_o !== mask) begin
        fails++;
        $display("FAIL %s oe bit %0d: got %h expected %h", name, k, bus_if.spi_oe_o, mask);
      end
      if (abort_after >= 0 && k == last) break;
      bus_if.spi_sclk_i = 1'b1;
      tick(HALF);
      bus_if.spi_sclk_i = 1'b0;
      fall_idx = k + 1;
      tick(HALF);
    end
    if (abort_after >= 0) begin
      bus_if.spi_cs_i = 1'b1;
      tick(SYNC + 3);
      tests++;
      if (done_log.size() - d0 != 0) begin
        fails++;
        $display("FAIL %s abort_done: got %0d pulses expected 0", name, done_log.size() - d0);
      end
    end else begin
      tick(4);
      tests++;
      if (done_log.size() - d0 != 1) begin
        fails++;
        $display("FAIL %s done_count: got %0d expected 1", name, done_log.size() - d0);
      end else begin
        tests++;
        if (done_log[d0] != cnt + 1) begin
          fails++;
          $display("FAIL %s done_edge: got %0d expected %0d", name, done_log[d0], cnt + 1);
        end
      end
      tests++;
      if (bus_if.spi_oe_o !== 4'h0) begin
        fails++;
        $display("FAIL %s oe_after_done: got %h expected 0", name, bus_if.spi_oe_o);
      end
      bus_if.spi_cs_i = 1'b1;
      tick(SYNC + 3);
    end
    tests++;
    if (bus_if.spi_oe_o !== 4'h0 || bus_if.spi_sdo_o !== 4'h0) begin
      fails++;
      $display("FAIL %s deselect: got oe %h sdo %h expected 0 0", name, bus_if.spi_oe_o, bus_if.spi_sdo_o);
    end
    tests++;
    if (ur_log.size() - u0 != exp_ur.size()) begin
      fails++;
      $display("FAIL %s underrun_count: got %0d expected %0d", name, ur_log.size() - u0, exp_ur.size());
    end else begin
      for (int i = 0; i < exp_ur.size(); i++) begin
        tests++;
        if (ur_log[u0 + i] != exp_ur[i]) begin
          fails++;
          $display("FAIL %s underrun_edge %0d: got %0d expected %0d", name, i, ur_log[u0 + i], exp_ur[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    tests++;
    if (bus_if.spi_sdo_o !== 4'h0 || bus_if.spi_oe_o !== 4'h0) begin
      fails++;
      $display("FAIL reset_pins: got sdo %h oe %h expected 0 0", bus_if.spi_sdo_o, bus_if.spi_oe_o);
    end
    tests++;
    if (bus_if.done_o !== 1'b0 || bus_if.underrun_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses: got done %b underrun %b expected 0 0", bus_if.done_o, bus_if.underrun_o);
    end
    tests++;
    if (bus_if.data_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 1", bus_if.data_ready_o);
    end
    rst_n = 1'b1;
    mq.delete();
    tick(SYNC + 2);
  endtask

  task automatic test_single();
    push_word(32'hA500_0000);
    run_xfer(0, 7, -1, 1'b0, 1'b0, '0, "single");
  endtask

  task automatic test_quad();
    push_word(32'h1234_5678);
    push_word(32'h9ABC_DEF0);
    run_xfer(2, 15, -1, 1'b0, 1'b0, '0, "quad");
  endtask

  task automatic test_dual_underrun();
    push_word($urandom);
    run_xfer(1, 31, -1, 1'b0, 1'b0, '0, "dual_underrun");
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 5; i++) push_word($urandom);
    tests++;
    if (bus_if.data_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: got %b expected 0", bus_if.data_ready_o);
    end
    run_xfer(0, 7, -1, 1'b0, 1'b1, $urandom, "full_push_pop");
    run_xfer(2, 15, -1, 1'b0, 1'b1, $urandom, "push_pop_nonfull");
    run_xfer(0, 63, -1, 1'b0, 1'b0, '0, "drain");
  endtask

  task automatic test_cs_abort();
    push_word($urandom);
    push_word($urandom);
    run_xfer(0, 7, 3, 1'b0, 1'b0, '0, "cs_abort");
    run_xfer(0, 7, -1, 1'b0, 1'b0, '0, "after_abort");
  endtask

  task automatic test_upd_fe();
    push_word($urandom);
    push_word($urandom);
    run_xfer(2, 15, -1, 1'b1, 1'b0, '0, "upd_coinc_fe");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push_word($urandom);
    bus_if.spi_cs_i = 1'b0;
    tick(SYNC + 2);
    bus_if.mode_i = 2'd2;
    bus_if.cnt_i = CW'(31);
    bus_if.cnt_upd_i = 1'b1;
    tick(1);
    bus_if.cnt_upd_i = 1'b0;
    repeat (3) begin
      bus_if.spi_sclk_i = 1'b1;
      tick(HALF);
      bus_if.spi_sclk_i = 1'b0;
      tick(HALF);
    end
    rst_n = 1'b0;
    tick(1);
    tests++;
    if (bus_if.spi_sdo_o !== 4'h0 || bus_if.spi_oe_o !== 4'h0 || bus_if.done_o !== 1'b0 ||
        bus_if.underrun_o !== 1'b0 || bus_if.data_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: got sdo %h oe %h done %b ur %b rdy %b expected 0 0 0 0 1",
               bus_if.spi_sdo_o, bus_if.spi_oe_o, bus_if.done_o, bus_if.underrun_o, bus_if.data_ready_o);
    end
    rst_n = 1'b1;
    mq.delete();
    bus_if.spi_cs_i = 1'b1;
    tick(SYNC + 2);
    run_xfer(0, 3, -1, 1'b0, 1'b0, '0, "after_reset_flush");
  endtask

  task automatic test_max_cnt();
    push_word($urandom);
    run_xfer(2, 255, -1, 1'b0, 1'b0, '0, "max_cnt");
  endtask

  task automatic test_random();
    int n, m, c, ab;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) push_word($urandom);
      m  = $urandom_range(0, 3);
      c  = $urandom_range(0, 40);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, c) : -1;
      run_xfer(m, c, ab, 1'b0, 1'b0, '0, $sformatf("random%0d", it));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.spi_sclk_i   = 1'b0;
    bus_if.spi_cs_i     = 1'b1;
    bus_if.mode_i       = 2'd0;
    bus_if.cnt_i        = '0;
    bus_if.cnt_upd_i    = 1'b0;
    bus_if.data_i       = '0;
    bus_if.data_valid_i = 1'b0;
    test_reset();
    test_single();
    test_quad();
    test_dual_underrun();
    test_fifo_full();
    test_cs_abort();
    test_upd_fe();
    test_reset_mid();
    test_max_cnt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
